// File: rtl/store_merge_unit.sv
// Store-path narrowing and read-modify-write merge into a word-only data memory.
// Handles sb/sh/sw, rejecting misaligned and reserved-size stores with a one-cycle err pulse.
module store_merge_unit #(
  parameter int WADDR_W = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_data,
  input  logic [1:0]         req_size,
  output logic               mem_en,
  output logic               mem_we,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  logic [2:0]         state;
  logic               live;
  logic [WADDR_W-1:0] addr_q;
  logic [31:0]        data_q;
  logic [31:0]        wdata_q;
  logic [1:0]         size_q;
  logic [1:0]         lane_q;
  logic               accept;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane replacement; untouched lanes keep the memory word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      SIZE_B:  m[{lane, 3'b000} +: 8]        = data[7:0];
      SIZE_H:  m[{lane[1], 4'b0000} +: 16]   = data[15:0];
      default: m                             = data;
    endcase
    return m;
  endfunction

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      live    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lane_q  <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr[WADDR_W+1:2];
            data_q <= req_data;
            size_q <= req_size;
            lane_q <= req_addr[1:0];
            if (misaligned(req_size, req_addr[1:0])) begin
              state <= ERR;
            end else if (req_size == SIZE_W) begin
              wdata_q <= req_data;
              state   <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ:  state <= MERGE;
        // mem_rdata is valid here, one cycle after the read strobe.
        MERGE: begin
          wdata_q <= merge_lane(mem_rdata, data_q, size_q, lane_q);
          state   <= WRITE;
        end
        WRITE:   state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // live keeps req_ready low until the first clock after reset release.
  assign req_ready = live && (state == IDLE);
  assign mem_en    = (state == READ) || (state == WRITE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = (state == WRITE) ? wdata_q : 32'h0;
  assign done      = (state == WRITE);
  assign err       = (state == ERR);

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: vector table, hand-built corner sequences and random
// stores checked against a byte-array reference model of the store rules.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;

  int n_cmp;
  int n_fail;

  store_merge_unit #(.WADDR_W(30)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small word memory: registered read, write on strobe, plus a preload port.
  logic [31:0] tbmem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;
  int          wr_count;

  always @(posedge clk) begin
    if (pl_en) begin
      tbmem[pl_idx] <= pl_val;
    end else if (mem_en && mem_we) begin
      tbmem[mem_addr[3:0]] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= tbmem[mem_addr[3:0]];
    if (mem_en && mem_we) wr_count <= wr_count + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] mem_init;
    logic        exp_err;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [1:0] size);
    logic [7:0] b [4];
    int a;
    a = int'(addr % 4);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (size == 2'd0) begin
      b[a] = data[7:0];
    end else if (size == 2'd1) begin
      b[a]   = data[7:0];
      b[a+1] = data[15:8];
    end else begin
      for (int i = 0; i < 4; i++) b[i] = data[8*i +: 8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = v;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic wait_ready(input string nm, output logic ok);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_store(input string nm, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input logic [31:0] init, input logic exp_err,
                           input logic [31:0] exp_word, input int exp_lat);
    logic ok;
    int done_cnt, err_cnt, reads, writes, pulse_cyc, ready_cyc, addr_bad, both;
    logic [31:0] wd;
    logic [3:0] idx;
    idx = addr[5:2];
    preload(idx, init);
    wait_ready(nm, ok);
    if (!ok) return;
    done_cnt = 0; err_cnt = 0; reads = 0; writes = 0; pulse_cyc = 0;
    ready_cyc = 0; addr_bad = 0; both = 0; wd = '0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
      end
      if (done) begin done_cnt++; pulse_cyc = c; wd = mem_wdata; end
      if (err) begin err_cnt++; pulse_cyc = c; end
      if (done && err) both = 1;
      if (mem_en && !mem_we) reads++;
      if (mem_en && mem_we) writes++;
      if (mem_en && ({2'b00, mem_addr} != {2'b00, addr[31:2]})) addr_bad = 1;
      if (req_ready && ready_cyc == 0) ready_cyc = c;
    end
    chk({nm, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
    chk({nm, "_err_cnt"}, err_cnt, exp_err ? 1 : 0);
    chk({nm, "_both"}, both, 0);
    chk({nm, "_latency"}, pulse_cyc, exp_lat);
    chk({nm, "_ready_back"}, ready_cyc, exp_lat + 1);
    chk({nm, "_reads"}, reads, (exp_err || size == 2'd2) ? 0 : 1);
    chk({nm, "_writes"}, writes, exp_err ? 0 : 1);
    chk({nm, "_mem_addr"}, addr_bad, 0);
    if (!exp_err) chk({nm, "_wdata"}, wd, exp_word);
    chk({nm, "_mem_word"}, tbmem[idx], exp_err ? init : exp_word);
  endtask

  initial begin
    logic ok;
    int dcount, strobes, first_ready;
    logic [7:0] dmask;
    int wc0;
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0; wr_count = 0; mem_rdata = '0;

    vecs[0] = '{32'h10, 32'hDEADBEEF, 2'd2, 32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[1] = '{32'h13, 32'h123456AB, 2'd0, 32'h11223344, 1'b0, 32'hAB223344, 3};
    vecs[2] = '{32'h12, 32'hFFFF5566, 2'd1, 32'h11223344, 1'b0, 32'h55663344, 3};
    vecs[3] = '{32'h10, 32'hFFFF5566, 2'd1, 32'h11223344, 1'b0, 32'h11225566, 3};
    vecs[4] = '{32'h11, 32'hFFFF5566, 2'd1, 32'h11223344, 1'b1, 32'h0,        1};
    vecs[5] = '{32'h02, 32'hDEADBEEF, 2'd2, 32'h55AA55AA, 1'b1, 32'h0,        1};
    vecs[6] = '{32'h08, 32'hDEADBEEF, 2'd3, 32'h01020304, 1'b1, 32'h0,        1};
    vecs[7] = '{32'h14, 32'h000000CC, 2'd0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5CC, 3};
    vecs[8] = '{32'h15, 32'h99887777, 2'd0, 32'h00000000, 1'b0, 32'h00007700, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", {26'd0, mem_en, mem_we, done, err, req_ready, |mem_wdata}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    reset = 1'b1;
    #1 chk("rst_ready_before_edge", req_ready, 1'b0);
    @(negedge clk);
    chk("rst_ready_after_release", req_ready, 1'b1);

    for (int i = 0; i < 9; i++)
      run_store($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].size,
                vecs[i].mem_init, vecs[i].exp_err, vecs[i].exp_word, vecs[i].exp_lat);

    // Back-to-back: byte store, then word store with req_valid held high
    preload(4'd4, 32'h11223344);
    preload(4'd8, 32'h00000000);
    wait_ready("b2b", ok);
    if (ok) begin
      dcount = 0; strobes = 0; first_ready = 0; dmask = '0;
      req_valid = 1'b1; req_addr = 32'h13; req_data = 32'h123456AB; req_size = 2'd0;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 1) begin req_addr = 32'h20; req_data = 32'hCAFEBABE; req_size = 2'd2; end
        if (c == 5) req_valid = 1'b0;
        if (done) begin dcount++; dmask[c] = 1'b1; end
        if (mem_en) strobes++;
        if (req_ready && first_ready == 0) first_ready = c;
      end
      chk("b2b_done_count", dcount, 2);
      chk("b2b_done_cycles", dmask, 8'b0010_1000);
      chk("b2b_second_accept", first_ready, 4);
      chk("b2b_strobes", strobes, 3);
      chk("b2b_byte_word", tbmem[4], 32'hAB223344);
      chk("b2b_word_word", tbmem[8], 32'hCAFEBABE);
    end

    // Reset during MERGE of a byte store
    preload(4'd6, 32'h11111111);
    wait_ready("rstmid", ok);
    if (ok) begin
      req_valid = 1'b1; req_addr = 32'h1B; req_data = 32'h00000022; req_size = 2'd0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_read_strobe", {mem_en, mem_we}, 2'b10);
      @(negedge clk);
      wc0 = wr_count;
      #1 reset = 1'b0;
      #1;
      chk("rstmid_outputs", {27'd0, mem_en, mem_we, done, err, req_ready}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rstmid_no_done", done, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_no_write", wr_count, wc0);
      chk("rstmid_mem_kept", tbmem[6], 32'h11111111);
      run_store("rstmid_fresh", 32'h20, 32'h0BADF00D, 2'd2, 32'h0, 1'b0, 32'h0BADF00D, 1);
    end

    // Random stores against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d, init;
      logic [1:0]  s;
      logic        e;
      a = $urandom_range(0, 63);
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      init = $urandom;
      e = ref_err(a, s);
      run_store($sformatf("rnd%0d", i), a, d, s, init, e, ref_store(init, a, d, s),
                e ? 1 : ((s == 2'd2) ? 1 : 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
